// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RISC-V sequencing controller: drives the shared ALU, the shared memory port and the
// register file through a per-instruction state sequence, with a memory-wait timeout and a retire counter.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// FETCH    | read instruction at PC, PC <= PC + 4 on completion
// DECODE   | latch opcode, compute branch target into ALUOut
// EXEC_R   | rs1 op rs2 (funct decode)
// EXEC_I   | rs1 + imm
// MEM_ADDR | rs1 + imm address for load/store
// MEM_RD   | data read at ALUOut
// MEM_WR   | data write at ALUOut, retires on completion
// WB_ALU   | write ALU result to rd, retires
// WB_MEM   | write memory data to rd, retires
// BRANCH   | compare rs1/rs2, load target when equal, retires
// JUMP     | load target, retires
// TRAP     | sticky error, left only through reset

module multicycle_ctrl_fsm #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic [6:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_source,
    output logic        reg_write,
    output logic        mem_2_reg,
    output logic        instr_done,
    output logic [31:0] retired,
    output logic        trap,
    output logic [3:0]  state
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_EXEC_R   = 4'd2;
    localparam logic [3:0] S_EXEC_I   = 4'd3;
    localparam logic [3:0] S_MEM_ADDR = 4'd4;
    localparam logic [3:0] S_MEM_RD   = 4'd5;
    localparam logic [3:0] S_MEM_WR   = 4'd6;
    localparam logic [3:0] S_WB_ALU   = 4'd7;
    localparam logic [3:0] S_WB_MEM   = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JUMP     = 4'd10;
    localparam logic [3:0] S_TRAP     = 4'd15;

    localparam logic [6:0] OP_ALU_R = 7'b0110011;
    localparam logic [6:0] OP_ALU_I = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    logic [3:0]  state_q, state_d;
    logic [6:0]  op_q, op_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] retired_q, retired_d;
    logic        mem_wait;

    // Shared handshake decision for the three request states: complete, time out, or keep waiting.
    function automatic logic [4:0] mem_step(input logic rdy, input logic [7:0] cnt,
                                            input logic [3:0] done_st, input logic [3:0] hold_st);
        if (rdy)
            return {1'b0, done_st};
        else if (cnt == TIMEOUT_CNT)
            return {1'b0, S_TRAP};
        else
            return {1'b1, hold_st};
    endfunction

    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        alu_src_a  = 2'd0;
        alu_src_b  = 2'd0;
        alu_op     = 2'b00;
        pc_source  = 2'd0;
        reg_write  = 1'b0;
        mem_2_reg  = 1'b0;
        instr_done = 1'b0;
        trap       = 1'b0;
        mem_wait   = 1'b0;
        state_d    = state_q;

        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                {mem_wait, state_d} = mem_step(mem_ready, wait_cnt_q, S_DECODE, S_FETCH);
            end
            S_DECODE: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd2;
                case (opcode)
                    OP_ALU_R:          state_d = S_EXEC_R;
                    OP_ALU_I:          state_d = S_EXEC_I;
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
                    OP_BEQ:            state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JUMP;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = 2'd1;
                alu_op    = 2'b10;
                state_d   = S_WB_ALU;
            end
            S_EXEC_I: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
                state_d   = S_WB_ALU;
            end
            S_MEM_ADDR: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
                case (op_q)
                    OP_LOAD:  state_d = S_MEM_RD;
                    OP_STORE: state_d = S_MEM_WR;
                    default:  state_d = S_TRAP;
                endcase
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                {mem_wait, state_d} = mem_step(mem_ready, wait_cnt_q, S_WB_MEM, S_MEM_RD);
            end
            S_MEM_WR: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
                {mem_wait, state_d} = mem_step(mem_ready, wait_cnt_q, S_FETCH, S_MEM_WR);
            end
            S_WB_ALU: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_2_reg  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 2'd1;
                alu_op     = 2'b01;
                pc_source  = 2'd1;
                pc_write   = zero;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                pc_source  = 2'd1;
                pc_write   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase
    end

    // Any state change is an entry into a fresh access, so the counter restarts there.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_d != state_q)
            wait_cnt_d = 8'd0;
        else if (mem_wait)
            wait_cnt_d = wait_cnt_q + 8'd1;
    end

    assign op_d      = (state_q == S_DECODE) ? opcode : op_q;
    assign retired_d = instr_done ? retired_q + 32'd1 : retired_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= S_FETCH;
            op_q       <= 7'd0;
            wait_cnt_q <= 8'd0;
            retired_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            wait_cnt_q <= wait_cnt_d;
            retired_q  <= retired_d;
        end
    end

    assign retired = retired_q;
    assign state   = state_q;

endmodule

// File: doc/multicycle_ctrl_fsm.md
# multicycle_ctrl_fsm

Sequencing controller for the multi-cycle build of the RISC-V core. It replaces the single-cycle control decoder and drives one shared ALU, one shared instruction/data memory port and the register file through a per-instruction state sequence. It waits on a variable-latency memory handshake, traps on illegal opcodes or memory timeout, and counts retired instructions.

## Interface
- MEM_TIMEOUT, 15: maximum wait cycles per memory access before trapping; range 1–255.
- clk  in  1  rising-edge clock.
- arst_n  in  1  asynchronous active-low reset.
- opcode  in  7  instruction[6:0] from the datapath IR; valid from DECODE onward.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access at this rising edge.
- pc_write  out  1  PC register load enable.
- ir_write  out  1  IR load enable.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read / mem_write  out  1 each  memory request strobes; held until the access completes.
- alu_src_a  out  2  ALU A select: 0 = PC, 1 = rs1, 2 = oldPC.
- alu_src_b  out  2  ALU B select: 0 = rs2, 1 = constant 4, 2 = imm.
- alu_op  out  2  00 add, 01 sub, 10 R-type funct decode.
- pc_source  out  2  0 = ALU result, 1 = ALUOut.
- reg_write / mem_2_reg  out  1 each  register file write enable; write-back select.
- instr_done  out  1  high in the final cycle of each instruction.
- retired  out  32  retired-instruction count; wraps modulo 2^32.
- trap  out  1  sticky error flag.
- state  out  4  current state encoding, for debug.

## Operation
- Opcodes: 0110011 ALU_R, 0010011 ALU_I, 1100011 BEQ, 1101111 JAL (no link), 0000011 LOAD, 0100011 STORE.
- Every output not listed for a state is 0 in that state. All outputs are decoded from the state register and the latched opcode `op_q`.

**States and actions**
- FETCH (0): mem_read=1, i_or_d=0, src_a=0, src_b=1, alu_op=00.
  - If mem_ready=1: ir_write=1, pc_write=1, pc_source=0, go to DECODE.
  - Otherwise: stay.
- DECODE (1): src_a=2, src_b=2, alu_op=00 to compute the branch target into ALUOut. Latch op_q=opcode.
  - ALU_R goes to EXEC_R. ALU_I goes to EXEC_I. LOAD and STORE go to MEM_ADDR. BEQ goes to BRANCH. JAL goes to JUMP. Any other opcode goes to TRAP.
- EXEC_R (2): src_a=1, src_b=0, alu_op=10, then go to WB_ALU.
- EXEC_I (3): src_a=1, src_b=2, alu_op=00, then go to WB_ALU.
- MEM_ADDR (4): src_a=1, src_b=2, alu_op=00. LOAD goes to MEM_RD; STORE goes to MEM_WR.
- MEM_RD (5): mem_read=1, i_or_d=1. On mem_ready go to WB_MEM; otherwise stay.
- MEM_WR (6): mem_write=1, i_or_d=1. On mem_ready: instr_done=1, go to FETCH.
- WB_ALU (7): reg_write=1, mem_2_reg=0, instr_done=1, go to FETCH.
- WB_MEM (8): reg_write=1, mem_2_reg=1, instr_done=1, go to FETCH.
- BRANCH (9): src_a=1, src_b=0, alu_op=01, pc_source=1, pc_write=zero, instr_done=1, go to FETCH.
- JUMP (10): pc_source=1, pc_write=1, instr_done=1, go to FETCH.
- TRAP (15): all strobes 0, trap=1. Only arst_n exits this state.

**Wait counter**
- An 8-bit `wait_cnt` clears on entry to FETCH, MEM_RD or MEM_WR, and increments each cycle the request is held without mem_ready.
- When wait_cnt reaches MEM_TIMEOUT and mem_ready=0, go to TRAP; no strobe fires.
- When mem_ready=1 on the same edge, completion wins.

**Retired counter**
- `retired` increments by 1 at each rising edge where instr_done=1.
- 0xFFFFFFFF wraps to 0.

**Unused encodings**
- Encodings 11–14 go to TRAP on the next edge.

## Timing
- Reset (arst_n low, asynchronous): state=FETCH, op_q=0, wait_cnt=0, retired=0.
  - trap is combinational from state, so it is 0 in reset.
  - Outputs during reset follow FETCH decode: mem_read=1, src_b=1, all others 0. ir_write=pc_write=mem_ready, pc_source=0.
  - Reset release is synchronised externally. The first edge after release may complete a fetch.
- Reset mid-instruction aborts it: no write strobe appears after arst_n falls, and retired does not increment.
- Memory handshake: a request is held constant until the edge where mem_ready=1. mem_ready is ignored in states that make no request.
- Cycles per instruction with zero-wait memory (mem_ready tied high):
  - BEQ and JAL: 3.
  - R-type, I-type and STORE: 4.
  - LOAD: 5.
  - Each wait cycle adds 1.
- instr_done and the corresponding architectural write occur in the same cycle.

## Test plan
- mem_ready=1; program ADD, ADDI, LW, SW, BEQ (taken), JAL → state sequence matches Operation; CPI 4, 4, 5, 4, 3, 3; retired=6 after 23 cycles.
- BEQ with zero=0 → pc_write=0 throughout BRANCH; instr_done=1; retired increments.
- LW with mem_ready delayed 3 cycles in both FETCH and MEM_RD → mem_read held steady; CPI=11; no trap.
- MEM_TIMEOUT=4 and mem_ready stuck low in MEM_WR → TRAP after 4 wait cycles; mem_write never completes; trap stays 1 until arst_n.
- opcode=7'b1111111 at DECODE → TRAP next cycle; all strobes 0; retired unchanged.
- Preload retired=0xFFFFFFFF by forcing, then retire one instruction → retired=0. Separately, assert arst_n low mid-MEM_WR → state=FETCH and retired=0 immediately.
